ray_scan_dispatcher: RTL and testbench

//  Upstream driver of the ray/sphere intersector. Walks the image plane in raster order and builds one ray per pixel
//  (camera origin -> image-plane point). Issues each ray over the intersector's ENABLE/READY handshake.

---
 rtl/rtrt_pkg.sv | 41 ++++
 rtl/ray_scan_counter.sv | 50 +++++
 rtl/ray_scan_dispatcher.sv | 215 +++++++++++++++++++++
 tb/tb_ray_scan_dispatcher.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtrt_pkg.sv
// Shared types and helpers for the ray-scan dispatcher and its raster counter.
package rtrt_pkg;

   typedef logic [15:0] coord_t;
   typedef coord_t vec3_t [3];

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StArm,
      StWait,
      StEmit,
      StDone
   } disp_state_e;

   // Intersector comparison threshold driven on every ray.
   localparam logic [3:0] THRESHOLD = 4'd2;

   // |a - b| on sign-extended 17-bit operands, saturated to 16 bits.
   function automatic coord_t abs_diff_sat(input coord_t a, input coord_t b);
      logic signed [16:0] diff;
      logic [16:0]        mag;
      diff = $signed({a[15], a}) - $signed({b[15], b});
      mag  = diff[16] ? 17'(-diff) : 17'(diff);
      return mag[16] ? 16'hFFFF : mag[15:0];
   endfunction

   // 255 - (depth >> shift), floored at 0.
   function automatic logic [7:0] depth_shade(input coord_t depth, input int unsigned shift);
      coord_t     scaled;
      logic [8:0] shade9;
      scaled = depth >> shift;
      if (scaled > 16'd255) begin
         shade9 = 9'd0;
      end else begin
         shade9 = 9'd255 - {1'b0, scaled[7:0]};
      end
      return shade9[7:0];
   endfunction

endpackage

// File: rtl/ray_scan_counter.sv
// Raster-order pixel counter: x runs 0..H_RES-1, then wraps and y advances.
module ray_scan_counter import rtrt_pkg::*; #(
   parameter int unsigned H_RES = 640,
   parameter int unsigned V_RES = 480
) (
   input  logic   i_clk,
   input  logic   i_reset_n,
   input  logic   i_clear,
   input  logic   i_advance,
   output coord_t o_x,
   output coord_t o_y,
   output coord_t o_x_nxt,
   output coord_t o_y_nxt,
   output logic   o_last
);

   coord_t r_x;
   coord_t r_y;
   logic   w_line_end;

   assign w_line_end = (r_x == coord_t'(H_RES - 1));
   assign o_last     = w_line_end && (r_y == coord_t'(V_RES - 1));
   assign o_x        = r_x;
   assign o_y        = r_y;

   // Next raster position, exposed so the caller can prebuild the next ray.
   always_comb begin
      o_x_nxt = r_x + 16'd1;
      o_y_nxt = r_y;
      if (w_line_end) begin
         o_x_nxt = '0;
         o_y_nxt = o_last ? '0 : r_y + 16'd1;
      end
   end

   // Position register: clear wins over advance.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_clear) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_advance) begin
         r_x <= o_x_nxt;
         r_y <= o_y_nxt;
      end
   end

endmodule

// File: rtl/ray_scan_dispatcher.sv
// Walks the image plane in raster order, issues one ray per pixel to the
// intersector and streams a depth/shade record per pixel to the framebuffer.
module ray_scan_dispatcher import rtrt_pkg::*; #(
   parameter int unsigned H_RES       = 640,
   parameter int unsigned V_RES       = 480,
   parameter int unsigned TIMEOUT     = 4096,
   parameter int unsigned DEPTH_SHIFT = 4,
   parameter logic [7:0]  BG_SHADE    = 8'd0
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_start,
   input  vec3_t      i_cam,
   input  coord_t     i_plane_z,
   input  coord_t     i_x_off,
   input  coord_t     i_y_off,
   output logic       o_rs_enable,
   output vec3_t      o_rs_p0,
   output vec3_t      o_rs_p1,
   output logic       o_rs_bounded,
   output logic [3:0] o_rs_threshold,
   input  logic       i_rs_ready,
   input  logic       i_rs_collide,
   input  vec3_t      i_rs_pint0,
   input  vec3_t      i_rs_pint1,
   output logic       o_pix_valid,
   input  logic       i_pix_ready,
   output coord_t     o_pix_x,
   output coord_t     o_pix_y,
   output logic       o_pix_hit,
   output coord_t     o_pix_depth,
   output logic [7:0] o_pix_shade,
   output logic       o_busy,
   output logic       o_frame_done,
   output logic       o_timeout_err
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   disp_state_e r_state;
   disp_state_e w_state_nxt;

   vec3_t       r_p0;
   vec3_t       r_p1;
   coord_t      r_plane_z;
   coord_t      r_x_off;
   coord_t      r_y_off;
   logic [TW-1:0] r_wait_cnt;
   logic        r_hit;
   coord_t      r_depth;
   logic [7:0]  r_shade;
   logic        r_timeout_err;

   logic        w_start_acc;
   logic        w_advance;
   logic        w_capture;
   logic        w_timeout;
   coord_t      w_x;
   coord_t      w_y;
   coord_t      w_x_nxt;
   coord_t      w_y_nxt;
   logic        w_last;
   coord_t      w_d0;
   coord_t      w_d1;
   coord_t      w_dmin;
   logic        w_unused_pint;

   // Only the z components of the intersection points feed the depth.
   assign w_unused_pint = ^{i_rs_pint0[0], i_rs_pint0[1], i_rs_pint1[0], i_rs_pint1[1]};

   ray_scan_counter #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_counter (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clear   (w_start_acc),
      .i_advance (w_advance),
      .o_x       (w_x),
      .o_y       (w_y),
      .o_x_nxt   (w_x_nxt),
      .o_y_nxt   (w_y_nxt),
      .o_last    (w_last)
   );

   assign w_d0   = abs_diff_sat(i_rs_pint0[2], r_p0[2]);
   assign w_d1   = abs_diff_sat(i_rs_pint1[2], r_p0[2]);
   assign w_dmin = (w_d0 < w_d1) ? w_d0 : w_d1;

   // Next-state and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      w_advance   = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_start_acc = 1'b1;
               w_state_nxt = StIssue;
            end
         end
         StIssue: w_state_nxt = StArm;
         // Dead cycle: READY left over from the previous ray must not be sampled.
         StArm:   w_state_nxt = StWait;
         StWait: begin
            if (i_rs_ready) begin
               w_capture   = 1'b1;
               w_state_nxt = StEmit;
            end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = StEmit;
            end
         end
         StEmit: begin
            if (i_pix_ready) begin
               if (w_last) begin
                  w_state_nxt = StDone;
               end else begin
                  w_advance   = 1'b1;
                  w_state_nxt = StIssue;
               end
            end
         end
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame parameters and ray endpoints; P1 is rebuilt from the next raster position.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_p0      <= '{default: '0};
         r_p1      <= '{default: '0};
         r_plane_z <= '0;
         r_x_off   <= '0;
         r_y_off   <= '0;
      end else if (w_start_acc) begin
         r_p0      <= i_cam;
         r_p1      <= '{i_x_off, i_y_off, i_plane_z};
         r_plane_z <= i_plane_z;
         r_x_off   <= i_x_off;
         r_y_off   <= i_y_off;
      end else if (w_advance) begin
         r_p1[0] <= w_x_nxt + r_x_off;
         r_p1[1] <= w_y_nxt + r_y_off;
         r_p1[2] <= r_plane_z;
      end
   end

   // Cycles spent in WAIT for the current ray.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wait_cnt <= '0;
      end else if (r_state == StWait) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
         r_wait_cnt <= '0;
      end
   end

   // Pixel result: captured on READY, forced to a miss on timeout.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_hit   <= 1'b0;
         r_depth <= '0;
         r_shade <= '0;
      end else if (w_capture) begin
         r_hit   <= i_rs_collide;
         r_depth <= i_rs_collide ? w_dmin : '0;
         r_shade <= i_rs_collide ? depth_shade(w_dmin, DEPTH_SHIFT) : BG_SHADE;
      end else if (w_timeout) begin
         r_hit   <= 1'b0;
         r_depth <= '0;
         r_shade <= BG_SHADE;
      end
   end

   // Sticky timeout flag, cleared by an accepted START.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_timeout_err <= 1'b0;
      end else if (w_start_acc) begin
         r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
         r_timeout_err <= 1'b1;
      end
   end

   assign o_rs_enable    = (r_state == StIssue);
   assign o_rs_p0        = r_p0;
   assign o_rs_p1        = r_p1;
   assign o_rs_bounded   = 1'b0;
   assign o_rs_threshold = THRESHOLD;
   assign o_pix_valid    = (r_state == StEmit);
   assign o_pix_x        = w_x;
   assign o_pix_y        = w_y;
   assign o_pix_hit      = r_hit;
   assign o_pix_depth    = r_depth;
   assign o_pix_shade    = r_shade;
   assign o_busy         = (r_state != StIdle);
   assign o_frame_done   = (r_state == StDone);
   assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_ray_scan_dispatcher.sv
// Scoreboard bench for ray_scan_dispatcher on a 2x2 frame with a stub intersector.
module tb_ray_scan_dispatcher;
   import rtrt_pkg::*;

   localparam int unsigned HR = 2;
   localparam int unsigned VR = 2;
   localparam int unsigned TO = 16;
   localparam int unsigned DS = 4;
   localparam logic [7:0]  BG = 8'd7;

   typedef struct {
      coord_t     x;
      coord_t     y;
      logic       hit;
      coord_t     depth;
      logic [7:0] shade;
   } rec_t;

   typedef struct packed {
      coord_t p0x, p0y, p0z, p1x, p1y, p1z;
   } ray_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   vec3_t      cam;
   coord_t     plane_z, x_off, y_off;
   logic       rs_enable;
   vec3_t      rs_p0, rs_p1;
   logic       rs_bounded;
   logic [3:0] rs_threshold;
   logic       rs_ready;
   logic       rs_collide;
   vec3_t      rs_pint0, rs_pint1;
   logic       pix_valid;
   logic       pix_ready = 1'b1;
   coord_t     pix_x, pix_y, pix_depth;
   logic       pix_hit;
   logic [7:0] pix_shade;
   logic       busy, frame_done, timeout_err;

   // Stub intersector configuration
   logic       stub_hit = 1'b0;
   logic       stub_never = 1'b0;
   int         stub_delay = 10;
   coord_t     stub_p0z = '0, stub_p1z = '0;
   logic       st_pend;
   int         st_cnt;

   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;
   int n_enable = 0;
   rec_t exp_q[$];
   ray_t ray_q[$];

   always #5 clk = ~clk;

   ray_scan_dispatcher #(
      .H_RES       (HR),
      .V_RES       (VR),
      .TIMEOUT     (TO),
      .DEPTH_SHIFT (DS),
      .BG_SHADE    (BG)
   ) dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_start        (start),
      .i_cam          (cam),
      .i_plane_z      (plane_z),
      .i_x_off        (x_off),
      .i_y_off        (y_off),
      .o_rs_enable    (rs_enable),
      .o_rs_p0        (rs_p0),
      .o_rs_p1        (rs_p1),
      .o_rs_bounded   (rs_bounded),
      .o_rs_threshold (rs_threshold),
      .i_rs_ready     (rs_ready),
      .i_rs_collide   (rs_collide),
      .i_rs_pint0     (rs_pint0),
      .i_rs_pint1     (rs_pint1),
      .o_pix_valid    (pix_valid),
      .i_pix_ready    (pix_ready),
      .o_pix_x        (pix_x),
      .o_pix_y        (pix_y),
      .o_pix_hit      (pix_hit),
      .o_pix_depth    (pix_depth),
      .o_pix_shade    (pix_shade),
      .o_busy         (busy),
      .o_frame_done   (frame_done),
      .o_timeout_err  (timeout_err)
   );

   assign rs_collide  = stub_hit;
   assign rs_pint0[0] = 16'd11;
   assign rs_pint0[1] = 16'd12;
   assign rs_pint0[2] = stub_p0z;
   assign rs_pint1[0] = 16'd21;
   assign rs_pint1[1] = 16'd22;
   assign rs_pint1[2] = stub_p1z;

   // Stub: drops READY on ENABLE, raises it stub_delay+1 cycles later unless stub_never.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_ready <= 1'b0;
         st_pend  <= 1'b0;
         st_cnt   <= 0;
      end else if (rs_enable) begin
         rs_ready <= 1'b0;
         st_pend  <= 1'b1;
         st_cnt   <= stub_delay;
      end else if (st_pend && !stub_never) begin
         if (st_cnt == 0) begin
            rs_ready <= 1'b1;
            st_pend  <= 1'b0;
         end else begin
            st_cnt <= st_cnt - 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // Monitor: check each issued ray and each accepted pixel record against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rs_enable) begin
            n_enable++;
            if (ray_q.size() == 0) begin
               chk("ray_unexpected", 1, 0);
            end else begin
               ray_t r;
               r = ray_q.pop_front();
               chk("ray_p0x", rs_p0[0], r.p0x);
               chk("ray_p0y", rs_p0[1], r.p0y);
               chk("ray_p0z", rs_p0[2], r.p0z);
               chk("ray_p1x", rs_p1[0], r.p1x);
               chk("ray_p1y", rs_p1[1], r.p1y);
               chk("ray_p1z", rs_p1[2], r.p1z);
            end
         end
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               chk("pix_unexpected", 1, 0);
            end else begin
               rec_t e;
               e = exp_q.pop_front();
               chk("pix_x", pix_x, e.x);
               chk("pix_y", pix_y, e.y);
               chk("pix_hit", pix_hit, e.hit);
               chk("pix_depth", pix_depth, e.depth);
               chk("pix_shade", pix_shade, e.shade);
            end
         end
         if (frame_done) n_done++;
      end
   end

   task automatic push_frame(input logic hit, input coord_t depth, input logic [7:0] shade);
      for (int y = 0; y < VR; y++) begin
         for (int x = 0; x < HR; x++) begin
            exp_q.push_back('{coord_t'(x), coord_t'(y), hit, depth, shade});
            ray_q.push_back({cam[0], cam[1], cam[2],
                             coord_t'(x) + x_off, coord_t'(y) + y_off, plane_z});
         end
      end
   endtask

   task automatic do_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_done);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (frame_done) got = 1'b1;
      end
      chk(name, got, 1);
      @(negedge clk);
      @(negedge clk);
      chk({name, "_cnt"}, n_done, exp_done);
      chk({name, "_expq"}, exp_q.size(), 0);
      chk({name, "_rayq"}, ray_q.size(), 0);
      chk({name, "_idle"}, busy, 0);
   endtask

   initial begin
      logic   stable;
      logic   got;
      coord_t hx, hy;
      int     en0;

      cam[0] = 16'd1; cam[1] = 16'd2; cam[2] = 16'd3;
      plane_z = 16'd50; x_off = 16'd100; y_off = 16'd200;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_enable", rs_enable, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_p1x", rs_p1[0], 0);
      chk("rst_shade", pix_shade, 0);
      chk("rst_thresh", rs_threshold, 2);
      chk("rst_bounded", rs_bounded, 0);

      // Misses after a 10-cycle intersector
      stub_hit = 1'b0; stub_delay = 10;
      push_frame(1'b0, 16'd0, BG);
      do_start();
      wait_done("miss_frame", 1);

      // Hit: depths 100 and 40 -> 40, shade 253
      cam[2] = 16'd1000; stub_hit = 1'b1; stub_delay = 3;
      stub_p0z = 16'd1100; stub_p1z = 16'd1040;
      push_frame(1'b1, 16'd40, 8'd253);
      do_start();
      wait_done("hit40_frame", 2);

      // Hit below the camera: |-100| vs 60 -> 60, shade 252; offsets wrap
      stub_p0z = 16'd900; stub_p1z = 16'd1060; x_off = 16'hFFFF; y_off = 16'hFFFF;
      push_frame(1'b1, 16'd60, 8'd252);
      do_start();
      wait_done("hit60_frame", 3);

      // Far hit saturates shade to 0
      cam[2] = 16'd0; stub_p0z = 16'd5000; stub_p1z = 16'd6000;
      x_off = 16'd100; y_off = 16'd200;
      push_frame(1'b1, 16'd5000, 8'd0);
      do_start();
      wait_done("sat_frame", 4);

      // Intersector never answers: forced misses, sticky error
      stub_never = 1'b1;
      push_frame(1'b0, 16'd0, BG);
      do_start();
      wait_done("timeout_frame", 5);
      chk("timeout_err_set", timeout_err, 1);

      // Backpressure plus an ignored START mid-frame
      stub_never = 1'b0; stub_hit = 1'b0; stub_delay = 3;
      pix_ready = 1'b0;
      push_frame(1'b0, 16'd0, BG);
      do_start();
      @(negedge clk);
      chk("timeout_err_clr", timeout_err, 0);
      chk("busy_set", busy, 1);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (pix_valid) got = 1'b1;
      end
      chk("bp_valid_seen", got, 1);
      hx = pix_x; hy = pix_y;
      en0 = n_enable;
      cam[0] = 16'd999; cam[2] = 16'd777; x_off = 16'd5;
      do_start();
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!pix_valid || pix_x !== hx || pix_y !== hy || pix_shade !== BG) stable = 1'b0;
      end
      chk("bp_record_stable", stable, 1);
      chk("bp_no_enable", n_enable - en0, 0);
      @(posedge clk);
      #1 pix_ready = 1'b1;
      wait_done("bp_frame", 6);
      cam[0] = 16'd1; cam[2] = 16'd3; x_off = 16'd100;

      // Reset while waiting on the intersector
      stub_never = 1'b1;
      push_frame(1'b0, 16'd0, BG);
      do_start();
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (rs_enable) got = 1'b1;
      end
      chk("rw_enable_seen", got, 1);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rw_busy", busy, 0);
      chk("rw_enable", rs_enable, 0);
      chk("rw_valid", pix_valid, 0);
      chk("rw_p0z", rs_p0[2], 0);
      chk("rw_p1x", rs_p1[0], 0);
      chk("rw_terr", timeout_err, 0);
      exp_q.delete();
      ray_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      stub_never = 1'b0; stub_delay = 2;
      @(negedge clk);
      chk("rw_no_done", n_done, 6);
      push_frame(1'b0, 16'd0, BG);
      do_start();
      wait_done("restart_frame", 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
